// File: rtl/uart_led_ctrl.sv
// Byte command responder between uart_rx and uart_tx streams: 'W' writes the LED register,
// 'R' reads it back, 'B' returns a status snapshot, anything else answers '?'.
module uart_led_ctrl #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] status,
    output logic [7:0] leds_reg
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        SEND0,
        SEND1
    } state_t;

    state_t        state_q, state_d;
    logic          s_rdy_q, s_rdy_d;
    logic          m_vld_q, m_vld_d;
    logic [7:0]    m_data_q, m_data_d;
    logic [7:0]    byte1_q, byte1_d;
    logic          two_q, two_d;
    logic [7:0]    leds_q, leds_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic s_hs, m_hs;

    assign s_hs          = s_axis_tvalid && s_rdy_q;
    assign m_hs          = m_vld_q && m_axis_tready;
    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_data_q;
    assign leds_reg      = leds_q;

    always_comb begin
        state_d  = state_q;
        s_rdy_d  = s_rdy_q;
        m_vld_d  = m_vld_q;
        m_data_d = m_data_q;
        byte1_d  = byte1_q;
        two_d    = two_q;
        leds_d   = leds_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                // Ready comes up one edge after reset release and stays up while idle.
                s_rdy_d = 1'b1;
                if (s_hs) begin
                    unique case (s_axis_tdata)
                        8'h57: begin
                            state_d = WAIT_DATA;
                            cnt_d   = '0;
                        end
                        8'h52: begin
                            state_d  = SEND0;
                            s_rdy_d  = 1'b0;
                            m_vld_d  = 1'b1;
                            m_data_d = 8'h52;
                            byte1_d  = leds_q;
                            two_d    = 1'b1;
                        end
                        8'h42: begin
                            state_d  = SEND0;
                            s_rdy_d  = 1'b0;
                            m_vld_d  = 1'b1;
                            m_data_d = 8'h42;
                            byte1_d  = status;
                            two_d    = 1'b1;
                        end
                        default: begin
                            state_d  = SEND0;
                            s_rdy_d  = 1'b0;
                            m_vld_d  = 1'b1;
                            m_data_d = 8'h3F;
                            two_d    = 1'b0;
                        end
                    endcase
                end
            end
            WAIT_DATA: begin
                cnt_d = (cnt_q == TERM) ? cnt_q : cnt_q + 1'b1;
                // A data byte on the terminal-count edge takes priority over the timeout.
                if (s_hs) begin
                    state_d  = SEND0;
                    s_rdy_d  = 1'b0;
                    leds_d   = s_axis_tdata;
                    m_vld_d  = 1'b1;
                    m_data_d = 8'h4B;
                    two_d    = 1'b0;
                end else if (cnt_q == TERM) begin
                    state_d  = SEND0;
                    s_rdy_d  = 1'b0;
                    m_vld_d  = 1'b1;
                    m_data_d = 8'h54;
                    two_d    = 1'b0;
                end
            end
            SEND0: begin
                if (m_hs) begin
                    if (two_q) begin
                        state_d  = SEND1;
                        m_data_d = byte1_q;
                    end else begin
                        state_d = IDLE;
                        m_vld_d = 1'b0;
                        s_rdy_d = 1'b1;
                    end
                end
            end
            SEND1: begin
                if (m_hs) begin
                    state_d = IDLE;
                    m_vld_d = 1'b0;
                    s_rdy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            m_data_q <= 8'h00;
            byte1_q  <= 8'h00;
            two_q    <= 1'b0;
            leds_q   <= 8'h00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s_rdy_q  <= s_rdy_d;
            m_vld_q  <= m_vld_d;
            m_data_q <= m_data_d;
            byte1_q  <= byte1_d;
            two_q    <= two_d;
            leds_q   <= leds_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/uart_led_ctrl.md
# uart_led_ctrl

Byte-level command responder between the `uart_rx` AXI-stream output and the `uart_tx` AXI-stream input on the Kintex board. It accepts host commands from the UART receive path and drives an 8-bit LED register. It samples an 8-bit status word and returns response bytes on the UART transmit path. It replaces the plain loopback in the top level.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz.
- `TIMEOUT_CYCLES`, CLK_FREQ/100, maximum wait for the data byte of a `W` command (10 ms).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset: asynchronous, active-low.
- `s_axis_tdata`  in  8  command byte from `uart_rx`.
- `s_axis_tvalid`  in  1  command byte valid.
- `s_axis_tready`  out  1  block can accept a byte (registered).
- `m_axis_tdata`  out  8  response byte to `uart_tx`.
- `m_axis_tvalid`  out  1  response byte valid (registered).
- `m_axis_tready`  in  1  `uart_tx` accepts the byte.
- `status`  in  8  status word, for example buttons. It is synchronous to `clk`.
- `leds_reg`  out  8  LED register.

## Operation
- A handshake occurs on a rising edge when `tvalid && tready` is high. Each handshake transfers exactly one byte.
- FSM states:
  - IDLE: `s_axis_tready`=1.
  - WAIT_DATA: `s_axis_tready`=1, timeout counter running.
  - SEND0: first response byte, `s_axis_tready`=0.
  - SEND1: second response byte, `s_axis_tready`=0.
- Commands accepted in IDLE:
  - `0x57` ('W') -> WAIT_DATA, timeout counter cleared to 0.
  - `0x52` ('R') -> SEND0 with byte0 = 0x52, byte1 = current `leds_reg`.
  - `0x42` ('B') -> SEND0 with byte0 = 0x42, byte1 = `status` captured on the accept edge. Later changes to `status` do not alter the queued byte.
  - Any other value -> SEND0 with single byte 0x3F ('?').
- In WAIT_DATA:
  - Data handshake -> `leds_reg` <= data, then SEND0 with single byte 0x4B ('K').
  - Counter reaches TIMEOUT_CYCLES-1 with no handshake -> SEND0 with single byte 0x54 ('T'). `leds_reg` is unchanged.
  - Data handshake on the same cycle as terminal count -> the data wins and the response is 'K'.
- In SEND0: on the `m_axis` handshake, go to SEND1 for two-byte responses, otherwise go to IDLE.
- In SEND1: on the `m_axis` handshake, go to IDLE.
- Input bytes are never dropped. Upstream holds them while `s_axis_tready`=0, because `uart_rx` buffers.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)`. It saturates (no wrap) and is cleared on entry to WAIT_DATA.

## Timing
- Reset values while `rst`=0:
  - state = IDLE.
  - `s_axis_tready` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0x00.
  - `leds_reg` = 0x00.
  - timeout counter = 0.
- `s_axis_tready` rises on the first `clk` edge after `rst` is released.
- Command accepted at edge N -> `m_axis_tvalid`=1 with byte0 visible after edge N. `s_axis_tready`=0 after the same edge N.
- The only exception is 'W': `s_axis_tready` stays 1 after edge N.
- `leds_reg` update and `m_axis_tvalid` for 'K' happen on the same edge as the data handshake.
- For a two-byte response:
  - byte0 is accepted at edge M.
  - byte1 is on `m_axis_tdata` after edge M, and `m_axis_tvalid` stays 1 with no bubble.
- After the final `m_axis` handshake at edge K: `m_axis_tvalid`=0 and `s_axis_tready`=1 after edge K.
- Back-to-back commands: minimum of 1 + response-length cycles per command.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata` is held stable.
- Reset asserted mid-operation: all state clears immediately (asynchronous).
  - A pending response is discarded.
  - `leds_reg` returns to 0x00.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the 'W' accept edge.

## Test plan
- Write: send 0x57, 0xA5 with `m_axis_tready`=1 -> `leds_reg`=0xA5 on the data edge; one response byte 0x4B; `s_axis_tready` returns to 1.
- Read and status snapshot:
  - After the write, send 0x52 -> responses 0x52, 0xA5 on consecutive cycles.
  - Send 0x42 with `status`=0x3C, then change it to 0xFF during backpressure -> responses 0x42, 0x3C.
- Unknown command: send 0x00 and 0xFF -> 0x3F for each; `leds_reg` unchanged.
- Timeout: with TIMEOUT_CYCLES=16, send 0x57 and no data -> 0x54 exactly 16 cycles later; `leds_reg` unchanged.
  - Repeat with the data byte arriving on cycle 15 -> 0x4B, LEDs updated.
- Backpressure: hold `m_axis_tready`=0 for 50 cycles during an 'R' response -> `m_axis_tdata` stable, `s_axis_tready`=0 throughout; both bytes delivered in order on release.
- Reset mid-command: assert `rst`=0 in WAIT_DATA and during SEND1 -> outputs go to reset values immediately; the next 0x52 returns 0x52, 0x00.
